// File: rtl/ram_write_sequencer.sv
// Write-port sequencer for the 32x8 two-port RAM demo: debounces two pushbuttons and
// issues single-cycle writes (manual or auto-increment address) or a full zero-fill sweep.
module ram_write_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mode_auto,
    input  logic              write_key,
    input  logic              clear_key,
    output logic [ADDR_W-1:0] wraddr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   wcount
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [ADDR_W:0]   WCOUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    // Index 0 is the write key, index 1 the clear key.
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {clear_key, write_key};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             s1_q, s2_q, db_q, armed_q, press_q;
        logic [1:0]       vld_q;
        logic [CNT_W-1:0] cnt_q;

        // vld_q marks when s2_q carries a real key sample rather than the reset preset;
        // a key must be seen released after reset before its presses count.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1_q    <= 1'b1;
                s2_q    <= 1'b1;
                db_q    <= 1'b1;
                cnt_q   <= '0;
                vld_q   <= '0;
                armed_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                s1_q    <= key_raw[k];
                s2_q    <= s1_q;
                vld_q   <= {vld_q[0], 1'b1};
                press_q <= 1'b0;
                if (vld_q[1] && s2_q) begin
                    armed_q <= 1'b1;
                end
                if (s2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    cnt_q   <= '0;
                    db_q    <= s2_q;
                    press_q <= armed_q & ~s2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[k] = press_q;
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic                wren_q, wren_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     wcount_q, wcount_d;
    logic                auto_q, auto_d;

    always_comb begin
        state_d  = state_q;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        wcount_d = wcount_q;
        auto_d   = auto_q;
        case (state_q)
            StIdle: begin
                if (press[1]) begin
                    state_d  = StClear;
                    busy_d   = 1'b1;
                    wraddr_d = '0;
                    wrdata_d = '0;
                    wren_d   = 1'b1;
                end else if (press[0]) begin
                    state_d  = StWrite;
                    wrdata_d = din;
                    wraddr_d = mode_auto ? ptr_q : addr_in;
                    wren_d   = 1'b1;
                    auto_d   = mode_auto;
                end
            end
            StWrite: begin
                state_d = StIdle;
                if (wcount_q != WCOUNT_MAX) begin
                    wcount_d = wcount_q + 1'b1;
                end
                if (auto_q) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StClear: begin
                if (wraddr_q == ADDR_LAST) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    ptr_d    = '0;
                    wcount_d = '0;
                end else begin
                    wraddr_d = wraddr_q + 1'b1;
                    wren_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            wraddr_q <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            wcount_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            wcount_q <= wcount_d;
            auto_q   <= auto_d;
        end
    end

    assign wraddr = wraddr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;
    assign busy   = busy_q;
    assign ptr    = ptr_q;
    assign wcount = wcount_q;

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Bench for ram_write_sequencer: vector table, hand-written corner sequences and
// random write/clear traffic checked against a transaction-level model.
module tb_ram_write_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [4:0] addr_in;
    logic       mode_auto;
    logic       write_key;
    logic       clear_key;
    logic [4:0] wraddr;
    logic [7:0] wrdata;
    logic       wren;
    logic       busy;
    logic [4:0] ptr;
    logic [5:0] wcount;

    ram_write_sequencer #(
        .ADDR_W   (5),
        .DATA_W   (8),
        .DB_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .addr_in  (addr_in),
        .mode_auto(mode_auto),
        .write_key(write_key),
        .clear_key(clear_key),
        .wraddr   (wraddr),
        .wrdata   (wrdata),
        .wren     (wren),
        .busy     (busy),
        .ptr      (ptr),
        .wcount   (wcount)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int log_a[$];
    int log_d[$];
    int busy_cycles = 0;

    always @(negedge clock) begin
        if (wren) begin
            log_a.push_back(int'(wraddr));
            log_d.push_back(int'(wrdata));
        end
        if (busy) busy_cycles++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic press_write();
        write_key = 1'b0;
        ticks(10);
        write_key = 1'b1;
        ticks(10);
    endtask

    task automatic press_clear();
        clear_key = 1'b0;
        ticks(10);
        clear_key = 1'b1;
        ticks(40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(5);
    endtask

    // Edge e counts from the first edge that samples the key low.
    task automatic press_timed(input int ea, input int ed);
        write_key = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 6) check("wren_before", int'(wren), 0);
            if (e == 7) begin
                check("wren_edge7", int'(wren), 1);
                check("wraddr_edge7", int'(wraddr), ea);
                check("wrdata_edge7", int'(wrdata), ed);
            end
            if (e == 8) check("wren_after", int'(wren), 0);
        end
        ticks(2);
        write_key = 1'b1;
        ticks(10);
    endtask

    task automatic check_sweep(input string nm);
        int errs = 0;
        check({nm, "_len"}, log_a.size(), 32);
        if (log_a.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                if (log_a[i] != i || log_d[i] != 0) errs++;
            end
        end
        check({nm, "_entries_bad"}, errs, 0);
    endtask

    typedef struct {
        bit m;
        int a;
        int d;
        int ea;
        int ed;
        int ep;
        int ew;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int ptr_m, wc_m, first, reached;

        tbl[0] = '{m: 0, a: 'h13, d: 'hA5, ea: 'h13, ed: 'hA5, ep: 0, ew: 1};
        tbl[1] = '{m: 1, a: 'h07, d: 'h3C, ea: 'h00, ed: 'h3C, ep: 1, ew: 2};
        tbl[2] = '{m: 1, a: 'h1E, d: 'h11, ea: 'h01, ed: 'h11, ep: 2, ew: 3};
        tbl[3] = '{m: 0, a: 'h1F, d: 'hFF, ea: 'h1F, ed: 'hFF, ep: 2, ew: 4};
        tbl[4] = '{m: 1, a: 'h00, d: 'h00, ea: 'h02, ed: 'h00, ep: 3, ew: 5};

        reset = 1'b1; din = '0; addr_in = '0; mode_auto = 1'b0;
        write_key = 1'b0; clear_key = 1'b1;

        // Reset with write key held down.
        ticks(3);
        check("rst_wraddr", int'(wraddr), 0);
        check("rst_wrdata", int'(wrdata), 0);
        check("rst_wren", int'(wren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ptr", int'(ptr), 0);
        check("rst_wcount", int'(wcount), 0);
        reset = 1'b0;
        ticks(20);
        check("held_through_reset", log_a.size(), 0);
        write_key = 1'b1;
        ticks(10);
        press_write();
        check("repress_count", log_a.size(), 1);

        // Table of single writes with exact latency.
        do_reset();
        foreach (tbl[i]) begin
            mode_auto = tbl[i].m;
            addr_in   = 5'(tbl[i].a);
            din       = 8'(tbl[i].d);
            press_timed(tbl[i].ea, tbl[i].ed);
            check("tbl_ptr", int'(ptr), tbl[i].ep);
            check("tbl_wcount", int'(wcount), tbl[i].ew);
        end

        // Auto-increment wrap and wcount saturation.
        do_reset();
        log_a.delete(); log_d.delete();
        mode_auto = 1'b1;
        for (int i = 0; i < 33; i++) begin
            din = 8'(i);
            press_write();
            check("wrap_count", log_a.size(), i + 1);
            if (log_a.size() == i + 1) begin
                check("wrap_addr", log_a[i], i % 32);
                check("wrap_data", log_d[i], i);
            end
        end
        check("wrap_ptr", int'(ptr), 1);
        check("wrap_wcount", int'(wcount), 32);

        // Bounce rejection.
        log_a.delete(); log_d.delete();
        din = 8'h09;
        for (int i = 0; i < 10; i++) begin
            write_key = (i % 2 == 1);
            ticks(2);
        end
        write_key = 1'b0;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (wren && first == 0) first = e;
        end
        write_key = 1'b1;
        ticks(10);
        check("bounce_edge", first, 7);
        check("bounce_count", log_a.size(), 1);

        // Clear sweep with a write press discarded mid-sweep.
        log_a.delete(); log_d.delete();
        busy_cycles = 0;
        clear_key = 1'b0;
        ticks(10);
        clear_key = 1'b1;
        write_key = 1'b0;
        ticks(10);
        write_key = 1'b1;
        ticks(30);
        check_sweep("clear");
        check("clear_busy_cycles", busy_cycles, 32);
        check("clear_ptr", int'(ptr), 0);
        check("clear_wcount", int'(wcount), 0);
        check("clear_busy_end", int'(busy), 0);

        // Random traffic against the transaction model.
        ptr_m = 0;
        wc_m  = 0;
        for (int n = 0; n < 30; n++) begin
            log_a.delete(); log_d.delete();
            if ($urandom_range(0, 7) == 0) begin
                press_clear();
                check_sweep("rnd_clear");
                ptr_m = 0;
                wc_m  = 0;
            end else begin
                mode_auto = 1'($urandom);
                addr_in   = 5'($urandom);
                din       = 8'($urandom);
                press_write();
                check("rnd_count", log_a.size(), 1);
                if (log_a.size() == 1) begin
                    check("rnd_addr", log_a[0], mode_auto ? ptr_m : int'(addr_in));
                    check("rnd_data", log_d[0], int'(din));
                end
                if (mode_auto) ptr_m = (ptr_m + 1) % 32;
                if (wc_m < 32) wc_m++;
            end
            check("rnd_ptr", int'(ptr), ptr_m);
            check("rnd_wcount", int'(wcount), wc_m);
        end

        // Simultaneous write and clear presses: clear wins.
        mode_auto = 1'b1;
        press_write();
        log_a.delete(); log_d.delete();
        write_key = 1'b0;
        clear_key = 1'b0;
        ticks(10);
        write_key = 1'b1;
        clear_key = 1'b1;
        ticks(40);
        check_sweep("prio");
        check("prio_wcount", int'(wcount), 0);
        check("prio_ptr", int'(ptr), 0);

        // Reset mid-sweep aborts it.
        press_write();
        press_write();
        press_write();
        check("abort_pre_ptr", int'(ptr), 3);
        clear_key = 1'b0;
        reached = 0;
        for (int i = 0; i < 60 && reached == 0; i++) begin
            tick();
            if (wren && busy && wraddr == 5'd10) reached = 1;
        end
        check("abort_reached", reached, 1);
        if (reached == 1) begin
            reset = 1'b1;
            tick();
            check("abort_wren", int'(wren), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_ptr", int'(ptr), 0);
            check("abort_wcount", int'(wcount), 0);
            reset = 1'b0;
        end
        clear_key = 1'b1;
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
